boot_sequencer: RTL and testbench

Boot and debug sequencer for the on-chip CPU. It sits between the UART byte interface, the CPU program memory port and the CPU control inputs. After reset it holds the CPU in reset and owns the memory port, then loads a length-prefixed program image received over UART. It then releases the CPU to run. On a `scan_memory` request it halts the CPU and streams the whole memory back out over UART TX.

---
 rtl/boot_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_boot_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer
// ---------------
// Boot and debug sequencer for the on-chip CPU. After reset the CPU is held in
// reset while the sequencer owns the program memory port and loads a
// length-prefixed image from the UART receiver. The CPU is then released to
// run. A rising edge on scan_memory halts the CPU and streams the whole memory
// out over the UART transmitter, after which the CPU resumes.
//
// Handshakes:
//   rx_valid is a one-cycle strobe; a byte is accepted on any edge where
//   rx_valid & ce is high in LEN or LOAD, and is ignored in every other state.
//   tx_valid/tx_ready is a strict valid/ready pair: once tx_valid rises,
//   tx_data and tx_valid hold until an edge where tx_valid & tx_ready & ce.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   ce              global clock enable; 0 freezes every register
//   scan_memory     asynchronous dump request (level, edge-triggered)
//   rx_data/valid   UART receive byte + strobe
//   tx_data/valid/ready  UART transmit byte handshake
//   mem_sel         1 = sequencer owns the memory port, 0 = CPU
//   mem_addr/wdata/we    memory write/read address and write strobe
//   mem_rdata       synchronous read data (valid the cycle after mem_addr)
//   cpu_rst         active-high CPU reset
//   cpu_ce          CPU clock enable (ce gated off unless running)
//   dbg_state       FSM state: 0 LEN, 1 LOAD, 2 RUN, 3 DUMP_RD, 4 DUMP_CAP,
//                   5 DUMP_TX

module boot_sequencer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              scan_memory,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rst,
  output logic              cpu_ce,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_LEN      = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN      = 3'd2,
    S_DUMP_RD  = 3'd3,
    S_DUMP_CAP = 3'd4,
    S_DUMP_TX  = 3'd5
  } state_t;

  localparam int                 CNT_W     = ADDR_W + 1;
  localparam int                 DEPTH     = 1 << ADDR_W;
  localparam logic [8:0]         DEPTH_9   = 9'(DEPTH);
  localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                cpu_run_q, cpu_run_d;
  logic                mem_sel_q, mem_sel_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                scan_prev_q, scan_prev_d;

  logic                scan_rise;
  logic [8:0]          len_ext;
  logic [CNT_W-1:0]    len_count;

  // Length byte to write count: 0 means a full image, oversize clamps to DEPTH.
  always_comb begin
    len_ext = 9'(rx_data);
    if ((len_ext == 9'd0) || (len_ext > DEPTH_9)) begin
      len_count = DEPTH_CNT;
    end else begin
      len_count = CNT_W'(len_ext);
    end
  end

  // The edge register keeps running in every state, so a rising edge seen
  // outside RUN is consumed there and never replayed later.
  assign scan_rise = sync2_q & ~scan_prev_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    cpu_rst_d   = cpu_rst_q;
    cpu_run_d   = cpu_run_q;
    mem_sel_d   = mem_sel_q;
    sync1_d     = scan_memory;
    sync2_d     = sync1_q;
    scan_prev_d = sync2_q;

    unique case (state_q)
      S_LEN: begin
        if (rx_valid) begin
          count_d = len_count;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // The pending write (we_q) commits on this edge: advance the address
        // and consume one unit of the count.
        if (we_q) begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q - CNT_W'(1);
        end
        if (we_q && (count_q == CNT_W'(1))) begin
          // Final write commits; a byte arriving on this same edge would be
          // one past the image and is dropped.
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
          cpu_run_d = 1'b1;
          mem_sel_d = 1'b0;
        end else if (rx_valid) begin
          wdata_d = rx_data;
          we_d    = 1'b1;
        end
      end

      S_RUN: begin
        if (scan_rise) begin
          state_d   = S_DUMP_RD;
          addr_d    = '0;
          mem_sel_d = 1'b1;
          cpu_run_d = 1'b0;
        end
      end

      S_DUMP_RD: begin
        state_d = S_DUMP_CAP;
      end

      S_DUMP_CAP: begin
        tx_data_d  = mem_rdata;
        tx_valid_d = 1'b1;
        state_d    = S_DUMP_TX;
      end

      S_DUMP_TX: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (addr_q == ADDR_LAST) begin
            state_d   = S_RUN;
            mem_sel_d = 1'b0;
            cpu_run_d = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_DUMP_RD;
          end
        end
      end

      default: begin
        state_d = S_LEN;
      end
    endcase
  end

  // ce gates every update; rx/tx handshakes therefore need ce implicitly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LEN;
      count_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      cpu_rst_q   <= 1'b1;
      cpu_run_q   <= 1'b0;
      mem_sel_q   <= 1'b1;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      scan_prev_q <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_run_q   <= cpu_run_d;
      mem_sel_q   <= mem_sel_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      scan_prev_q <= scan_prev_d;
    end
  end

  // A write held over a ce=0 stretch is masked, then lands once ce returns.
  assign mem_we    = we_q & ce;
  assign cpu_ce    = cpu_run_q & ce;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_sel   = mem_sel_q;
  assign cpu_rst   = cpu_rst_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
module tb_boot_sequencer;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [2:0] S_LEN     = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DUMP_RD = 3'd3;
  localparam logic [2:0] S_DUMP_TX = 3'd5;

  logic              clk;
  logic              rst_n;
  logic              ce;
  logic              scan_memory;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic              cpu_rst;
  logic              cpu_ce;
  logic [2:0]        dbg_state;

  boot_sequencer #(.ADDR_W(ADDR_W), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .scan_memory(scan_memory),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- program memory (synchronous read) ----------------
  logic [7:0] ram [DEPTH];
  logic [7:0] ram_rdata;
  always @(posedge clk) begin
    if (mem_we && mem_sel) ram[mem_addr] <= mem_wdata;
    ram_rdata <= ram[mem_addr];
  end
  assign mem_rdata = ram_rdata;

  // ---------------- reference model + scoreboard ----------------
  logic [7:0]        model_mem [DEPTH];
  int                model_addr;
  logic [ADDR_W+7:0] exp_wr_q[$];
  logic [7:0]        exp_tx_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                tx_count = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // write monitor
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none", mem_addr, mem_wdata);
      end else begin
        check("load_write", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
      end
    end
  end

  // transmit monitor: a byte leaves on an edge with valid & ready & ce
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ce === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_tx_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_tx: got 0x%0h expected none", tx_data);
      end else begin
        check("dump_byte", tx_data, exp_tx_q.pop_front());
      end
      tx_count++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_len(input logic [7:0] l);
    rx_data  = l;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b, input bit expect_write);
    logic [ADDR_W-1:0] a;
    rx_data  = b;
    rx_valid = 1'b1;
    if (expect_write) begin
      a = model_addr[ADDR_W-1:0];
      exp_wr_q.push_back({a, b});
      model_mem[model_addr] = b;
      model_addr = (model_addr + 1) % DEPTH;
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_addr = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst"},   cpu_rst,   1);
    check({tag, "_cpu_ce"},    cpu_ce,    0);
    check({tag, "_mem_sel"},   mem_sel,   1);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_tx_valid"},  tx_valid,  0);
    check({tag, "_tx_data"},   tx_data,   0);
    check({tag, "_state"},     dbg_state, S_LEN);
  endtask

  // Full dump from RUN; leaves scan_memory high. cycles counts edges spent
  // from entering DUMP_RD until RUN is reached again.
  task automatic do_dump(input bit stall5, input bit rnd_ready, output int cycles);
    int  base;
    bit  stalled;
    for (int i = 0; i < DEPTH; i++) exp_tx_q.push_back(model_mem[i]);
    base    = tx_count;
    stalled = 1'b0;
    scan_memory = 1'b1;
    tick();                       // edge e: first sample of the pin
    tick();                       // edge e+1
    check("dump_lat_e1_cpu_ce", cpu_ce, 1);
    tick();                       // edge e+2
    check("dump_lat_e2_cpu_ce", cpu_ce, 0);
    check("dump_lat_e2_state", dbg_state, S_DUMP_RD);
    check("dump_cpu_rst_low", cpu_rst, 0);
    cycles = 0;
    while (dbg_state != S_RUN && cycles < 3000) begin
      if (stall5 && !stalled && tx_valid && (tx_count - base) == 5) begin
        stalled  = 1'b1;
        tx_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
          tick();
          cycles++;
          check("stall_tx_valid", tx_valid, 1);
          check("stall_tx_data", tx_data, model_mem[5]);
          check("stall_addr", mem_addr, 5);
        end
        tx_ready = 1'b1;
      end else begin
        if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
        tick();
        cycles++;
      end
    end
    tx_ready = 1'b1;
    if (cycles >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dump_timeout: got no return to RUN expected RUN within 3000 cycles");
    end
    check("dump_end_mem_sel", mem_sel, 0);
    check("dump_end_cpu_ce", cpu_ce, 1);
    check("dump_byte_count", tx_count - base, DEPTH);
    check("dump_queue_empty", exp_tx_q.size(), 0);
  endtask

  // watchdog
  initial begin
    #1ms;
    n_bad++;
    $display("FAIL watchdog: got simulation still running expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int  cycles;
    int  ce_k;
    int  k;
    int  base;
    bit  found;

    rst_n = 1'b0; ce = 1'b1; scan_memory = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    model_addr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = 8'($urandom_range(0, 255));
      ram[i]       = model_mem[i];
    end
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // ---- short image, back-to-back ----
    send_len(8'd4);
    load_byte(8'h11, 1);
    load_byte(8'h22, 1);
    load_byte(8'h33, 1);
    load_byte(8'h44, 1);
    check("last_write_cpu_rst_still_high", cpu_rst, 1);
    check("last_write_we", mem_we, 1);
    tick();
    check("release_cpu_rst", cpu_rst, 0);
    check("release_mem_sel", mem_sel, 0);
    check("release_cpu_ce", cpu_ce, 1);
    check("release_state", dbg_state, S_RUN);
    check("short_writes_done", exp_wr_q.size(), 0);

    // dump with a 10-cycle stall on byte 5
    do_dump(1'b1, 1'b0, cycles);
    check("dump_cycles_stalled", cycles, 3 * DEPTH + 10);
    // pin held high: no retrigger
    repeat (20) tick();
    check("held_scan_no_redump", dbg_state, S_RUN);
    scan_memory = 1'b0;
    // bytes in RUN are ignored
    for (int i = 0; i < 3; i++) load_byte(8'($urandom_range(0, 255)), 0);
    tick();

    // ---- L=0 full image, ce dropout, scan toggle during load ----
    pulse_reset();
    check("reload_state_len", dbg_state, S_LEN);
    send_len(8'd0);
    ce_k = $urandom_range(20, 50);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 5)  scan_memory = 1'b1;
      if (i == 12) scan_memory = 1'b0;
      if (i == ce_k) begin
        ce = 1'b0;
        for (int j = 0; j < 5; j++) begin
          rx_data  = 8'($urandom_range(0, 255));
          rx_valid = 1'b1;
          tick();
          check("ce_low_no_write", mem_we, 0);
        end
        check("ce_low_cpu_ce", cpu_ce, 0);
        rx_valid = 1'b0;
        ce = 1'b1;
      end
      load_byte(8'($urandom_range(0, 255)), 1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();
    check("full_load_state_run", dbg_state, S_RUN);
    check("full_load_writes_done", exp_wr_q.size(), 0);
    repeat (10) tick();
    check("load_scan_toggle_ignored", dbg_state, S_RUN);
    ce = 1'b0;
    #1;
    check("run_ce_low_cpu_ce", cpu_ce, 0);
    ce = 1'b1;
    #1;
    do_dump(1'b0, 1'b0, cycles);
    check("dump_cycles_full", cycles, 3 * DEPTH);
    scan_memory = 1'b0;
    repeat (4) tick();

    // ---- L=200 clamp, extra bytes right at the end ----
    pulse_reset();
    send_len(8'd200);
    for (int i = 0; i < DEPTH; i++) load_byte(8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < 3; i++) load_byte(8'($urandom_range(0, 255)), 0);
    tick();
    check("clamp_state_run", dbg_state, S_RUN);
    check("clamp_writes_done", exp_wr_q.size(), 0);

    // reset in the middle of DUMP_TX with tx_valid high
    for (int i = 0; i < DEPTH; i++) exp_tx_q.push_back(model_mem[i]);
    base = tx_count;
    k = $urandom_range(1, 60);
    scan_memory = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (dbg_state == S_DUMP_TX && (tx_count - base) == k) found = 1'b1;
      else tick();
    end
    check("mid_dump_reached", found, 1);
    tx_ready = 1'b0;
    tick();
    check("mid_dump_tx_valid", tx_valid, 1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("mid_dump_reset");
    rst_n = 1'b1;
    tx_ready = 1'b1;
    scan_memory = 1'b0;
    exp_tx_q.delete();
    model_addr = 0;
    repeat (4) tick();

    // reload a small image and dump with random back-pressure
    send_len(8'd3);
    for (int i = 0; i < 3; i++) load_byte(8'($urandom_range(0, 255)), 1);
    tick();
    check("reload_state_run", dbg_state, S_RUN);
    do_dump(1'b0, 1'b1, cycles);
    scan_memory = 1'b0;
    repeat (4) tick();

    check("final_writes_done", exp_wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
